ram_port_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port RAM (`RAM_1Port`: one address bus, write strobe, read enable, one-cycle registered read with `o_Rd_DV`). Requesters A and B each present read or write commands through a request/grant handshake. The arbiter picks a winner round-robin, drives the RAM with registered commands, and returns each read result only to the requester that issued it. It sits between two client engines and one `RAM_1Port` instance.

---
 rtl/ram_arb_pkg.sv | 26 ++
 rtl/rr_arbiter_2.sv | 50 +++++
 rtl/ram_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ----------------------------------------------------------------------------
// ram_arb_pkg
// Shared types and constants for the two-requester RAM port arbiter.
//   req_id_e   : requester identity (A = 0, B = 1); also the priority pointer
//   RAM_RD_LAT : RAM read latency in cycles after it samples a read command
//   TAG_STAGES : read-tag pipeline depth (command register + RAM stage)
//   rd_tag_t   : {valid, id} tag that follows each read through the pipe
// ----------------------------------------------------------------------------
package ram_arb_pkg;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  localparam int RAM_RD_LAT = 1;

  // One stage for the registered command, RAM_RD_LAT stages for the RAM.
  localparam int TAG_STAGES = RAM_RD_LAT + 1;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// ----------------------------------------------------------------------------
// rr_arbiter_2
// Two-way round-robin arbiter. The grant is purely combinational from the
// request vector and the priority pointer. The pointer moves to the loser
// after every accepted command and holds otherwise.
//   i_Clk, i_Rst_L : clock, asynchronous active-low reset
//   i_Req[1:0]     : request vector, bit 0 = A, bit 1 = B
//   i_Accept       : a granted command transferred on this edge
//   o_Grant[1:0]   : one-hot (or zero) grant
// ----------------------------------------------------------------------------
module rr_arbiter_2
  import ram_arb_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [1:0] i_Req,
  input  logic       i_Accept,
  output logic [1:0] o_Grant
);

  req_id_e ptr_q, ptr_d;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value unassigned and infer a latch.
  always_comb begin
    o_Grant = 2'b00;
    ptr_d   = ptr_q;
    case (i_Req)
      2'b01:   o_Grant = 2'b01;
      2'b10:   o_Grant = 2'b10;
      2'b11:   o_Grant = (ptr_q == REQ_A) ? 2'b01 : 2'b10;
      default: o_Grant = 2'b00;
    endcase
    // Point at the requester that did not win.
    if (i_Accept) begin
      ptr_d = o_Grant[0] ? REQ_B : REQ_A;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      ptr_q <= REQ_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter
// Shares one single-port RAM (one-cycle registered read) between requesters
// A and B. Accepted commands are registered onto the RAM port; reads carry a
// {valid, id} tag down a pipeline aligned with the RAM so each returning
// beat is routed only to the requester that issued it.
//   i_Clk, i_Rst_L                : clock, asynchronous active-low reset
//   i_X_Req/Wr/Addr/Wr_Data       : requester X command (X = A, B)
//   o_X_Grant                     : combinational accept for requester X
//   o_X_Rd_DV, o_X_Rd_Data        : read response pulse and held data
//   o_Ram_Addr/Wr_DV/Wr_Data/Rd_En: registered RAM command
//   i_Ram_Rd_DV, i_Ram_Rd_Data    : RAM read return
// ----------------------------------------------------------------------------
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_A_Req,
  input  logic              i_A_Wr,
  input  logic [ADDR_W-1:0] i_A_Addr,
  input  logic [WIDTH-1:0]  i_A_Wr_Data,
  input  logic              i_B_Req,
  input  logic              i_B_Wr,
  input  logic [ADDR_W-1:0] i_B_Addr,
  input  logic [WIDTH-1:0]  i_B_Wr_Data,
  output logic              o_A_Grant,
  output logic              o_B_Grant,
  output logic              o_A_Rd_DV,
  output logic [WIDTH-1:0]  o_A_Rd_Data,
  output logic              o_B_Rd_DV,
  output logic [WIDTH-1:0]  o_B_Rd_Data,
  output logic [ADDR_W-1:0] o_Ram_Addr,
  output logic              o_Ram_Wr_DV,
  output logic [WIDTH-1:0]  o_Ram_Wr_Data,
  output logic              o_Ram_Rd_En,
  input  logic              i_Ram_Rd_DV,
  input  logic [WIDTH-1:0]  i_Ram_Rd_Data
);

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic [1:0] req, grant;
  logic       accept;

  assign req = {i_B_Req, i_A_Req};

  rr_arbiter_2 u_rr (
    .i_Clk    (i_Clk),
    .i_Rst_L  (i_Rst_L),
    .i_Req    (req),
    .i_Accept (accept),
    .o_Grant  (grant)
  );

  assign o_A_Grant = grant[0];
  assign o_B_Grant = grant[1];
  assign accept    = |(req & grant);

  // Winning command; only meaningful when accept is high.
  req_id_e           win_id;
  logic              win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [WIDTH-1:0]  win_wdata;

  always_comb begin
    win_id    = REQ_A;
    win_wr    = i_A_Wr;
    win_addr  = i_A_Addr;
    win_wdata = i_A_Wr_Data;
    if (grant[1]) begin
      win_id    = REQ_B;
      win_wr    = i_B_Wr;
      win_addr  = i_B_Addr;
      win_wdata = i_B_Wr_Data;
    end
  end

  // --------------------------------------------------------------------------
  // Registered RAM command
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_dv_q, wr_dv_d;
  logic              rd_en_q, rd_en_d;
  logic [WIDTH-1:0]  wr_data_q, wr_data_d;

  // Address and write data hold when idle; write data also holds on reads.
  always_comb begin
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    wr_dv_d   = 1'b0;
    rd_en_d   = 1'b0;
    if (accept) begin
      addr_d  = win_addr;
      wr_dv_d = win_wr;
      rd_en_d = !win_wr;
      if (win_wr) begin
        wr_data_d = win_wdata;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      addr_q    <= '0;
      wr_dv_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      addr_q    <= addr_d;
      wr_dv_q   <= wr_dv_d;
      rd_en_q   <= rd_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign o_Ram_Addr    = addr_q;
  assign o_Ram_Wr_DV   = wr_dv_q;
  assign o_Ram_Wr_Data = wr_data_q;
  assign o_Ram_Rd_En   = rd_en_q;

  // --------------------------------------------------------------------------
  // Read-tag pipeline: stage 0 lines up with the command register, the last
  // stage with the RAM's registered read data.
  // --------------------------------------------------------------------------
  rd_tag_t tag_q [TAG_STAGES];
  rd_tag_t tag_d;
  rd_tag_t ret_tag;

  assign tag_d   = '{valid: accept && !win_wr, id: win_id};
  assign ret_tag = tag_q[TAG_STAGES-1];

  // NOTE: this small array is deliberately reset: clearing the valid bits is
  // what drops reads that are in flight when reset hits.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int i = 0; i < TAG_STAGES; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < TAG_STAGES; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response demux. A RAM beat without a valid tag is ignored.
  // --------------------------------------------------------------------------
  logic             a_dv_q, a_dv_d, b_dv_q, b_dv_d;
  logic [WIDTH-1:0] a_data_q, a_data_d, b_data_q, b_data_d;

  always_comb begin
    a_dv_d   = i_Ram_Rd_DV && ret_tag.valid && (ret_tag.id == REQ_A);
    b_dv_d   = i_Ram_Rd_DV && ret_tag.valid && (ret_tag.id == REQ_B);
    a_data_d = a_dv_d ? i_Ram_Rd_Data : a_data_q;
    b_data_d = b_dv_d ? i_Ram_Rd_Data : b_data_q;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      a_dv_q   <= 1'b0;
      b_dv_q   <= 1'b0;
      a_data_q <= '0;
      b_data_q <= '0;
    end else begin
      a_dv_q   <= a_dv_d;
      b_dv_q   <= b_dv_d;
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
    end
  end

  assign o_A_Rd_DV   = a_dv_q;
  assign o_B_Rd_DV   = b_dv_q;
  assign o_A_Rd_Data = a_data_q;
  assign o_B_Rd_Data = b_data_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_port_arbiter
// Directed scenarios followed by random traffic. A behavioural RAM sits on
// the RAM port; the expected behaviour comes from a transaction-level model:
// a round-robin pointer, a memory array updated in acceptance order, and a
// queue of expected read responses each due three sampling windows after
// the window in which the read was accepted.
// ----------------------------------------------------------------------------
module tb_ram_port_arbiter;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              a_req, a_wr, b_req, b_wr;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [WIDTH-1:0]  a_wdata, b_wdata;
  logic              o_A_Grant, o_B_Grant, o_A_Rd_DV, o_B_Rd_DV;
  logic [WIDTH-1:0]  o_A_Rd_Data, o_B_Rd_Data;
  logic [ADDR_W-1:0] o_Ram_Addr;
  logic              o_Ram_Wr_DV, o_Ram_Rd_En;
  logic [WIDTH-1:0]  o_Ram_Wr_Data;
  logic              i_Ram_Rd_DV;
  logic [WIDTH-1:0]  i_Ram_Rd_Data;

  ram_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_A_Req       (a_req),
    .i_A_Wr        (a_wr),
    .i_A_Addr      (a_addr),
    .i_A_Wr_Data   (a_wdata),
    .i_B_Req       (b_req),
    .i_B_Wr        (b_wr),
    .i_B_Addr      (b_addr),
    .i_B_Wr_Data   (b_wdata),
    .o_A_Grant     (o_A_Grant),
    .o_B_Grant     (o_B_Grant),
    .o_A_Rd_DV     (o_A_Rd_DV),
    .o_A_Rd_Data   (o_A_Rd_Data),
    .o_B_Rd_DV     (o_B_Rd_DV),
    .o_B_Rd_Data   (o_B_Rd_Data),
    .o_Ram_Addr    (o_Ram_Addr),
    .o_Ram_Wr_DV   (o_Ram_Wr_DV),
    .o_Ram_Wr_Data (o_Ram_Wr_Data),
    .o_Ram_Rd_En   (o_Ram_Rd_En),
    .i_Ram_Rd_DV   (i_Ram_Rd_DV),
    .i_Ram_Rd_Data (i_Ram_Rd_Data)
  );

  // Behavioural single-port RAM, one-cycle registered read, no reset.
  logic [WIDTH-1:0] ram_mem [DEPTH];
  logic             ram_rd_dv_q = 1'b0;
  logic [WIDTH-1:0] ram_rd_data_q = '0;
  logic             stray = 1'b0;

  initial for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;

  always @(posedge clk) begin
    ram_rd_dv_q <= o_Ram_Rd_En;
    if (o_Ram_Rd_En) ram_rd_data_q <= ram_mem[o_Ram_Addr];
    if (o_Ram_Wr_DV) ram_mem[o_Ram_Addr] <= o_Ram_Wr_Data;
  end

  assign i_Ram_Rd_DV   = ram_rd_dv_q | stray;
  assign i_Ram_Rd_Data = ram_rd_data_q;

  // ---------------------------------------------------------------- model --
  typedef struct {
    int               due;
    bit               id;    // 0 = A, 1 = B
    logic [WIDTH-1:0] data;
  } exp_rd_t;

  exp_rd_t           exp_q[$];
  logic [WIDTH-1:0]  model_mem [DEPTH];
  bit                m_ptr;  // requester favoured when both ask
  logic [ADDR_W-1:0] m_addr;
  logic              m_wr_dv, m_rd_en;
  logic [WIDTH-1:0]  m_wdata, m_a_data, m_b_data;

  int cyc;
  int vectors;
  int miscompares;

  initial for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr    = 1'b0;
    m_addr   = '0;
    m_wr_dv  = 1'b0;
    m_rd_en  = 1'b0;
    m_wdata  = '0;
    m_a_data = '0;
    m_b_data = '0;
  endtask

  task automatic check_all_zero();
    check("rst_grant_a", o_A_Grant, 0);
    check("rst_grant_b", o_B_Grant, 0);
    check("rst_a_dv", o_A_Rd_DV, 0);
    check("rst_b_dv", o_B_Rd_DV, 0);
    check("rst_a_data", o_A_Rd_Data, 0);
    check("rst_b_data", o_B_Rd_Data, 0);
    check("rst_ram_addr", o_Ram_Addr, 0);
    check("rst_ram_wr_dv", o_Ram_Wr_DV, 0);
    check("rst_ram_wdata", o_Ram_Wr_Data, 0);
    check("rst_ram_rd_en", o_Ram_Rd_En, 0);
  endtask

  task automatic set_a(input logic req, input logic wr, input int addr, input int data);
    a_req = req; a_wr = wr; a_addr = ADDR_W'(addr); a_wdata = WIDTH'(data);
  endtask

  task automatic set_b(input logic req, input logic wr, input int addr, input int data);
    b_req = req; b_wr = wr; b_addr = ADDR_W'(addr); b_wdata = WIDTH'(data);
  endtask

  // One clock: check everything in mid-cycle, then advance the model with
  // whatever is accepted at the rising edge.
  task automatic cycle();
    logic ea, eb, ea_dv, eb_dv, w;
    logic [ADDR_W-1:0] ad;
    logic [WIDTH-1:0]  dt;
    @(negedge clk);
    ea = a_req && (!b_req || m_ptr == 1'b0);
    eb = b_req && !ea;
    check("grant_a", o_A_Grant, ea);
    check("grant_b", o_B_Grant, eb);
    ea_dv = 1'b0;
    eb_dv = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      if (exp_q[0].id) begin eb_dv = 1'b1; m_b_data = exp_q[0].data; end
      else             begin ea_dv = 1'b1; m_a_data = exp_q[0].data; end
      void'(exp_q.pop_front());
    end
    check("a_rd_dv", o_A_Rd_DV, ea_dv);
    check("b_rd_dv", o_B_Rd_DV, eb_dv);
    check("a_rd_data", o_A_Rd_Data, m_a_data);
    check("b_rd_data", o_B_Rd_Data, m_b_data);
    check("ram_addr", o_Ram_Addr, m_addr);
    check("ram_wr_dv", o_Ram_Wr_DV, m_wr_dv);
    check("ram_rd_en", o_Ram_Rd_En, m_rd_en);
    if (m_wr_dv) check("ram_wdata", o_Ram_Wr_Data, m_wdata);
    @(posedge clk);
    if (ea || eb) begin
      w  = ea ? a_wr    : b_wr;
      ad = ea ? a_addr  : b_addr;
      dt = ea ? a_wdata : b_wdata;
      m_addr  = ad;
      m_wr_dv = w;
      m_rd_en = !w;
      if (w) begin
        m_wdata       = dt;
        model_mem[ad] = dt;
      end else begin
        exp_q.push_back('{due: cyc + 3, id: eb, data: model_mem[ad]});
      end
      m_ptr = ea;  // loser gets priority next
    end else begin
      m_wr_dv = 1'b0;
      m_rd_en = 1'b0;
    end
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // -------------------------------------------------------------- stimulus --
  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    rst_n       = 1'b0;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    model_reset();

    @(negedge clk);
    check_all_zero();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // A alone writes 0x11..0x14 to addresses 0..3.
    for (int i = 0; i < 4; i++) begin
      set_a(1, 1, i, 8'h11 + i);
      cycle();
    end
    idle(2);

    // B reads 0..3 back-to-back.
    for (int i = 0; i < 4; i++) begin
      set_b(1, 0, i, 0);
      cycle();
    end
    idle(3);

    // Both read continuously: A at 1, B at 2.
    set_a(1, 0, 1, 0);
    set_b(1, 0, 2, 0);
    for (int i = 0; i < 6; i++) cycle();
    idle(3);

    // Read-after-write on consecutive edges.
    set_a(1, 1, 3, 8'h5A);
    set_b(0, 0, 0, 0);
    cycle();
    set_a(0, 0, 0, 0);
    set_b(1, 0, 3, 0);
    cycle();
    idle(3);

    // Reset while A's read is in flight (RAM beat present at reset time).
    set_a(1, 0, 0, 0);
    cycle();
    idle(1);
    @(negedge clk);
    check("ram_beat_inflight", i_Ram_Rd_DV, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero();
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    idle(2);
    set_a(1, 0, 0, 0);
    set_b(1, 0, 1, 0);
    cycle();
    idle(3);

    // Stray RAM beat with nothing outstanding.
    stray = 1'b1;
    idle(1);
    stray = 1'b0;
    idle(2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      set_a($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
            $urandom_range(0, 255));
      set_b($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
            $urandom_range(0, 255));
      cycle();
    end
    idle(4);
    check("responses_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
